// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared types and default timing for the RTC bus-cycle generator
package rtc_bus_pkg;

    localparam int RTC_T_PULSE = 10;
    localparam int RTC_T_GAP   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_GAP,
        ST_DATA,
        ST_DATA_GAP,
        ST_FIN
    } rtc_state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } rtc_op_t;

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtl/rtc_bus_ctrl_if.sv - processor request side and RTC pin side of the bus-cycle generator
interface rtc_bus_ctrl_if;
    logic       actRTC;
    logic [7:0] dir;
    logic       wr_strobe;
    logic       rd_strobe;
    logic [7:0] dato_in;
    logic [7:0] dato_rtc;
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       ad_sel;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport slave (
        input  actRTC, dir, wr_strobe, rd_strobe, dato_in, ad_in,
        output dato_rtc, busy, done, cs_n, ad_sel, wr_n, rd_n, ad_out, ad_oe
    );

    modport master (
        output actRTC, dir, wr_strobe, rd_strobe, dato_in, ad_in,
        input  dato_rtc, busy, done, cs_n, ad_sel, wr_n, rd_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter that flags the last cycle of a bus phase
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtl/rtc_bus_ctrl.sv - timed address/data bus-cycle generator for the external RTC chip
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_PULSE = RTC_T_PULSE,
    parameter int T_GAP   = RTC_T_GAP
) (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_ctrl_if.slave  bus
);

    localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int CW    = $clog2(T_MAX) + 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(T_GAP - 1);

    rtc_state_t    state_q, state_d;
    rtc_op_t       op_q;
    logic [7:0]    addr_q, data_q;
    logic          accept;
    logic          tmr_load, tmr_zero;
    logic [CW-1:0] tmr_val;

    logic          cs_n_q, wr_n_q, rd_n_q, ad_sel_q, ad_oe_q, busy_q, done_q;
    logic [7:0]    ad_out_q, dato_q;
    logic          cs_n_d, wr_n_d, rd_n_d, ad_sel_d, ad_oe_d, busy_d, done_d;
    logic [7:0]    ad_out_d;

    assign accept = (state_q == ST_IDLE) && bus.actRTC && (bus.wr_strobe || bus.rd_strobe);

    rtc_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept)   state_d = ST_ADDR;
            ST_ADDR:     if (tmr_zero) state_d = ST_ADDR_GAP;
            ST_ADDR_GAP: if (tmr_zero) state_d = ST_DATA;
            ST_DATA:     if (tmr_zero) state_d = ST_DATA_GAP;
            ST_DATA_GAP: if (tmr_zero) state_d = ST_FIN;
            ST_FIN:                    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase

        // Timer reloads on every phase change so each phase counts from its own length.
        tmr_load = (state_d != state_q);
        tmr_val  = (state_d == ST_ADDR || state_d == ST_DATA) ? PULSE_LOAD : GAP_LOAD;
    end

    // Pin values are decoded from the next state and registered, so pins change cleanly on the edge.
    always_comb begin
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        done_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        ad_sel_d = ad_sel_q;
        ad_oe_d  = ad_oe_q;
        ad_out_d = ad_out_q;
        case (state_d)
            ST_IDLE: begin
                ad_sel_d = 1'b0;
                ad_oe_d  = 1'b0;
            end
            ST_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_sel_d = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = accept ? bus.dir : addr_q;
            end
            ST_DATA: begin
                cs_n_d   = 1'b0;
                ad_sel_d = 1'b1;
                if (op_q == OP_WR) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_q;
                end else begin
                    rd_n_d  = 1'b0;
                    ad_oe_d = 1'b0;
                end
            end
            ST_FIN: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_WR;
            addr_q   <= '0;
            data_q   <= '0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            ad_sel_q <= 1'b0;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dato_q   <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.wr_strobe ? OP_WR : OP_RD;
                addr_q <= bus.dir;
                data_q <= bus.dato_in;
            end
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            ad_sel_q <= ad_sel_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (state_q == ST_DATA && tmr_zero && op_q == OP_RD) begin
                dato_q <= bus.ad_in;
            end
        end
    end

    assign bus.cs_n     = cs_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.ad_sel   = ad_sel_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_out   = ad_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dato_rtc = dato_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb/tb_rtc_bus_ctrl.sv - directed and randomized bench for rtc_bus_ctrl against a cycle-index model
module tb_rtc_bus_ctrl;

    localparam int TP   = 4;
    localparam int TG   = 2;
    localparam int LAST = 1 + 2 * (TP + TG);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rtc_bus_ctrl_if bus ();

    rtc_bus_ctrl #(.T_PULSE(TP), .T_GAP(TG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: k is the cycle index within the current transaction (0 = idle).
    int         k = 0;
    bit         m_wr = 1'b0;
    bit         m_from_reset = 1'b1;
    logic [7:0] m_addr = '0;
    logic [7:0] m_data = '0;
    logic [7:0] m_dato = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t (k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    function automatic int phase_of(input int kk);
        if (kk >= 1 && kk <= TP)                return 1;
        if (kk > TP && kk <= TP + TG)           return 2;
        if (kk > TP + TG && kk <= 2*TP + TG)    return 3;
        if (kk > 2*TP + TG && kk <= 2*TP + 2*TG) return 4;
        if (kk == LAST)                         return 5;
        return 0;
    endfunction

    task automatic model_edge();
        if (reset) begin
            k            = 0;
            m_dato       = '0;
            m_from_reset = 1'b1;
        end else if (k == 0) begin
            if (bus.actRTC && (bus.wr_strobe || bus.rd_strobe)) begin
                k            = 1;
                m_wr         = bus.wr_strobe;
                m_addr       = bus.dir;
                m_data       = bus.dato_in;
                m_from_reset = 1'b0;
            end
        end else begin
            if (!m_wr && k == 2*TP + TG) m_dato = bus.ad_in;
            k = (k == LAST) ? 0 : k + 1;
        end
    endtask

    task automatic check_outputs();
        int ph;
        ph = phase_of(k);
        check("busy",     bus.busy,     k != 0);
        check("done",     bus.done,     ph == 5);
        check("cs_n",     bus.cs_n,     !(ph == 1 || ph == 3));
        check("wr_n",     bus.wr_n,     !(ph == 1 || (ph == 3 && m_wr)));
        check("rd_n",     bus.rd_n,     !(ph == 3 && !m_wr));
        check("dato_rtc", bus.dato_rtc, m_dato);
        if (ph == 1 || ph == 3) check("ad_sel", bus.ad_sel, ph == 3);
        if (ph == 1 || ph == 2) begin
            check("ad_oe_addr",  bus.ad_oe,  1);
            check("ad_out_addr", bus.ad_out, m_addr);
        end
        if (ph == 3 || ph == 4) begin
            check("ad_oe_data", bus.ad_oe, m_wr);
            if (m_wr) check("ad_out_data", bus.ad_out, m_data);
        end
        if (ph == 0 && m_from_reset) begin
            check("ad_oe_rst",  bus.ad_oe,  0);
            check("ad_out_rst", bus.ad_out, 0);
            check("ad_sel_rst", bus.ad_sel, 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit act, input bit wr, input bit rd,
                         input logic [7:0] d, input logic [7:0] dat);
        bus.actRTC    = act;
        bus.wr_strobe = wr;
        bus.rd_strobe = rd;
        bus.dir       = d;
        bus.dato_in   = dat;
    endtask

    task automatic quiet();
        bus.wr_strobe = 1'b0;
        bus.rd_strobe = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        bus.ad_in = 8'h00;

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Write 0x59 to 0x21, with an ignored write strobe mid-transaction.
        drive(1'b1, 1'b1, 1'b0, 8'h21, 8'h59);
        step();
        for (int c = 1; c <= 13; c++) begin
            if (c == 5) drive(1'b1, 1'b1, 1'b0, 8'h99, 8'hEE);
            else        quiet();
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 8'h44, 8'h55);
        step();
        quiet();
        repeat (2) step();

        // Read from 0x24 returning 0x37.
        bus.ad_in = 8'h37;
        drive(1'b1, 1'b0, 1'b1, 8'h24, 8'h00);
        step();
        quiet();
        repeat (14) step();

        // Both strobes together: write wins.
        bus.ad_in = 8'hC3;
        drive(1'b1, 1'b1, 1'b1, 8'h30, 8'hA5);
        step();
        quiet();
        repeat (14) step();

        // Reset in cycle 8 of a read.
        bus.ad_in = 8'h6B;
        drive(1'b1, 1'b0, 1'b1, 8'h25, 8'h00);
        step();
        quiet();
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();

        // Back-to-back: second write accepted the cycle after done.
        drive(1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
        step();
        quiet();
        repeat (13) step();
        drive(1'b1, 1'b1, 1'b0, 8'hF0, 8'h3C);
        step();
        quiet();
        repeat (14) step();

        repeat (3000) begin
            reset         = ($urandom_range(0, 299) == 0);
            bus.actRTC    = ($urandom_range(0, 3) != 0);
            bus.wr_strobe = ($urandom_range(0, 5) == 0);
            bus.rd_strobe = ($urandom_range(0, 5) == 0);
            bus.dir       = 8'($urandom);
            bus.dato_in   = 8'($urandom);
            bus.ad_in     = 8'($urandom);
            step();
        end
        reset = 1'b0;
        quiet();
        repeat (16) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
